// File: rtl/ud_cnt_mod.sv
// ud_cnt_mod: parametrised up/down counter with load, [min,max] window,
// wrap/saturate/one-shot modes and boundary/compare flags.
module ud_cnt_mod #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             ce,
  input  logic             ud,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] min_v,
  input  logic [WIDTH-1:0] max_v,
  input  logic [WIDTH-1:0] cmp_v,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done,
  output logic             at_max,
  output logic             at_min,
  output logic             cmp_gt,
  output logic             cfg_err
);

  localparam logic [1:0] M_WRAP = 2'b00;
  localparam logic [1:0] M_ONE  = 2'b10;

  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             done_nxt;
  logic             run;
  logic             hit;

  assign at_max  = q >= max_v;
  assign at_min  = q <= min_v;
  assign cmp_gt  = q > cmp_v;
  assign cfg_err = min_v > max_v;

  assign run = ce & ~done & ~cfg_err;

  // Out-of-window q also counts as a boundary hit in the count direction
  assign hit = ud ? at_max : at_min;

  always_comb begin
    q_nxt    = q;
    tc_nxt   = 1'b0;
    done_nxt = done;
    if (clr) begin
      q_nxt    = RST_VAL;
      done_nxt = 1'b0;
    end else if (ld & ce) begin
      q_nxt    = d;
      done_nxt = 1'b0;
    end else if (run) begin
      if (!hit) begin
        q_nxt = ud ? q + WIDTH'(1) : q - WIDTH'(1);
      end else begin
        tc_nxt = 1'b1;
        unique case (mode)
          M_WRAP:  q_nxt    = ud ? min_v : max_v;
          M_ONE:   done_nxt = 1'b1;
          default: q_nxt    = q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RST_VAL;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= q_nxt;
      tc   <= tc_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ud_cnt_mod.sv
// tb_ud_cnt_mod: directed and randomized checks of ud_cnt_mod
// against a behavioural window-counter model.
module tb_ud_cnt_mod;

  logic       clk = 1'b0;
  logic       rst, clr, ld, ce, ud;
  logic [1:0] mode;
  logic [7:0] d, min_v, max_v, cmp_v;
  logic [7:0] q;
  logic       tc, done, at_max, at_min, cmp_gt, cfg_err;

  int errors = 0;
  int checks = 0;

  int mq    = 0;
  bit mtc   = 0;
  bit mdone = 0;

  ud_cnt_mod #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ce(ce),
    .ud(ud), .mode(mode), .d(d), .min_v(min_v),
    .max_v(max_v), .cmp_v(cmp_v), .q(q), .tc(tc),
    .done(done), .at_max(at_max), .at_min(at_min),
    .cmp_gt(cmp_gt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Flags are pure functions of the model count and current inputs
  task automatic chk_flags();
    chk("at_max", at_max, mq >= int'(max_v));
    chk("at_min", at_min, mq <= int'(min_v));
    chk("cmp_gt", cmp_gt, mq > int'(cmp_v));
    chk("cfg_err", cfg_err, int'(min_v) > int'(max_v));
  endtask

  task automatic step();
    int lo, hi, dir, nq;
    bit ntc, nd;
    lo  = int'(min_v);
    hi  = int'(max_v);
    dir = ud ? 1 : -1;
    nq  = mq;
    ntc = 0;
    nd  = mdone;
    if (clr) begin
      nq = 0;
      nd = 0;
    end else if (ld && ce) begin
      nq = int'(d);
      nd = 0;
    end else if (ce && !mdone && lo <= hi) begin
      if ((ud && mq < hi) || (!ud && mq > lo)) begin
        nq = mq + dir;
      end else begin
        ntc = 1;
        if (mode == 2'b00) nq = ud ? lo : hi;
        if (mode == 2'b10) nd = 1;
      end
    end
    @(posedge clk);
    #1;
    mq    = nq;
    mtc   = ntc;
    mdone = nd;
    chk("q", q, mq);
    chk("tc", tc, mtc);
    chk("done", done, mdone);
    chk_flags();
  endtask

  task automatic load(input logic [7:0] v);
    ld = 1; ce = 1; d = v;
    step();
    ld = 0;
  endtask

  initial begin
    rst = 1; clr = 0; ld = 0; ce = 0; ud = 1;
    mode = 2'b00; d = 0; min_v = 0; max_v = 8'hFF;
    cmp_v = 0;
    #1;
    chk("rst_q", q, 0);
    chk("rst_tc", tc, 0);
    chk("rst_done", done, 0);
    #6 rst = 0;

    // Reset in the middle of counting
    load(8'h36);
    ce = 1; ud = 1;
    step();
    chk("t1_q37", q, 8'h37);
    #3 rst = 1;
    #1;
    mq = 0; mtc = 0; mdone = 0;
    chk("t1_async_q", q, 0);
    chk("t1_async_tc", tc, 0);
    chk("t1_async_done", done, 0);
    #2 rst = 0;

    // Wrap window 3..5
    mode = 2'b00; min_v = 3; max_v = 5;
    load(8'd3);
    ce = 1; ud = 1;
    step(); chk("t2_q4", q, 4); chk("t2_tc0", tc, 0);
    step(); chk("t2_q5", q, 5);
    step(); chk("t2_q3", q, 3); chk("t2_tc1", tc, 1);
    step(); chk("t2_q4b", q, 4); chk("t2_tc0b", tc, 0);
    load(8'd3);
    ce = 1; ud = 0;
    step(); chk("t2_dn_q", q, 5); chk("t2_dn_tc", tc, 1);

    // Saturate at all-ones
    mode = 2'b01; min_v = 0; max_v = 8'hFF;
    load(8'hFE);
    ce = 1; ud = 1;
    step(); chk("t3_qff", q, 8'hFF); chk("t3_tc0", tc, 0);
    step(); chk("t3_hold", q, 8'hFF); chk("t3_tc1", tc, 1);
    step(); chk("t3_tc1b", tc, 1);
    ce = 0;
    step(); chk("t3_ce0_tc", tc, 0); chk("t3_ce0_q", q, 8'hFF);

    // One-shot down to 0
    mode = 2'b10; min_v = 0; ud = 0;
    load(8'd2);
    ce = 1; ud = 0;
    step(); chk("t4_q1", q, 1);
    step(); chk("t4_q0", q, 0); chk("t4_nd", done, 0);
    step(); chk("t4_done", done, 1); chk("t4_tc", tc, 1);
    step(); chk("t4_idle_q", q, 0); chk("t4_idle_tc", tc, 0);
    load(8'd9);
    chk("t4_ld_q", q, 9); chk("t4_ld_done", done, 0);

    // Priority and compare
    clr = 1; ld = 1; ce = 1; d = 8'h55;
    step(); chk("t5_clr_q", q, 0); chk("t5_clr_done", done, 0);
    clr = 0; ld = 1; ce = 0; d = 8'h55;
    step(); chk("t5_noload", q, 0);
    ld = 0;
    cmp_v = 8'h10;
    load(8'h11); chk("t5_gt1", cmp_gt, 1);
    load(8'h10); chk("t5_gt0", cmp_gt, 0);

    // Inverted window freezes counting
    mode = 2'b00; min_v = 9; max_v = 4;
    #1 chk("t6_err", cfg_err, 1);
    ce = 1; ud = 1;
    step(); chk("t6_frozen", q, 8'h10);
    load(8'd7); chk("t6_ld", q, 7);
    min_v = 2; ce = 1; ud = 0;
    #1 chk("t6_ok", cfg_err, 0);
    step(); chk("t6_resume", q, 6);

    // Randomized traffic with narrow windows to hit boundaries
    for (int i = 0; i < 600; i++) begin
      clr = ($urandom_range(0, 31) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      ud  = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        min_v = ($urandom_range(0, 7) == 0) ? 8'h00
              : 8'($urandom_range(0, 20));
        max_v = ($urandom_range(0, 7) == 0) ? 8'hFF
              : 8'($urandom_range(0, 30));
      end
      d     = ($urandom_range(0, 3) == 0) ? 8'($urandom)
            : 8'($urandom_range(0, 32));
      cmp_v = 8'($urandom_range(0, 32));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
